// File: rtl/wb_port_arb_pkg.sv
// Shared definitions for the register-file write-port arbiter.
// Source encodings, request packing and the grant enumeration.
package wb_port_arb_pkg;

  localparam logic WB_SRC_PIPE = 1'b0;
  localparam logic WB_SRC_MDU  = 1'b1;

  localparam int WB_RD_WIDTH     = 5;
  localparam int WB_DATA_WIDTH   = 32;
  localparam int WB_REQ_WIDTH    = WB_RD_WIDTH + WB_DATA_WIDTH;
  localparam int WB_STARVE_WIDTH = 4;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_PIPE = 2'd1,
    GRANT_MDU  = 2'd2
  } wb_grant_e;

  // Destination register sits in the upper bits of a packed request.
  function automatic logic [WB_REQ_WIDTH-1:0] wb_pack(
    input logic [WB_RD_WIDTH-1:0]   rd,
    input logic [WB_DATA_WIDTH-1:0] wdata
  );
    return {rd, wdata};
  endfunction

endpackage

// File: rtl/wb_starve_cnt.sv
// Starvation counter for the MDU requester: counts consecutive denied
// cycles, saturates at STARVE_MAX and raises force_grant when saturated.
module wb_starve_cnt
  import wb_port_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic req1_valid,
  input  logic req1_grant,
  output logic force_grant
);

  localparam logic [WB_STARVE_WIDTH-1:0] CNT_MAX = WB_STARVE_WIDTH'(STARVE_MAX);

  logic [WB_STARVE_WIDTH-1:0] starve_cnt;

  // Any gap in the MDU request restarts the count, so only truly
  // consecutive denials can build up to a forced grant.
  always_ff @(posedge clock) begin
    if (reset || req1_grant || !req1_valid) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_MAX) begin
      starve_cnt <= starve_cnt + WB_STARVE_WIDTH'(1);
    end
  end

  assign force_grant = (starve_cnt == CNT_MAX);

endmodule

// File: rtl/wb_port_arb.sv
// Write-port arbiter: pipeline writeback (fixed priority) vs. MDU, with a
// starvation guarantee for the MDU and a registered register-file write.
// Optional conflict statistics counter enabled by WB_ARB_STAT_EN.
//
// Handshake: a requester holds valid/rd/wdata stable until it sees its
// ready high; a transfer happens in any cycle where valid && ready.
module wb_port_arb
  import wb_port_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req0_valid_i,
  input  logic [WB_RD_WIDTH-1:0]   req0_rd_i,
  input  logic [WB_DATA_WIDTH-1:0] req0_wdata_i,
  output logic                     req0_ready_o,
  input  logic                     req1_valid_i,
  input  logic [WB_RD_WIDTH-1:0]   req1_rd_i,
  input  logic [WB_DATA_WIDTH-1:0] req1_wdata_i,
  output logic                     req1_ready_o,
  output logic                     rf_we_o,
  output logic [WB_RD_WIDTH-1:0]   rf_rd_o,
  output logic [WB_DATA_WIDTH-1:0] rf_wdata_o,
  output logic                     rf_src_o
`ifdef WB_ARB_STAT_EN
  ,
  output logic [31:0]              stat_conflict_o
`endif
);

  wb_grant_e                grant;
  logic                     force_grant;
  logic [WB_REQ_WIDTH-1:0]  sel_req;
  logic [WB_RD_WIDTH-1:0]   sel_rd;
  logic [WB_DATA_WIDTH-1:0] sel_wdata;
  logic                     sel_src;

  wb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clock       (clock),
    .reset       (reset),
    .req1_valid  (req1_valid_i),
    .req1_grant  (req1_ready_o),
    .force_grant (force_grant)
  );

  // A saturated starvation count overrides the pipeline's fixed priority.
  always_comb begin
    grant = GRANT_NONE;
    if (!reset) begin
      if (force_grant && req1_valid_i) begin
        grant = GRANT_MDU;
      end else if (req0_valid_i) begin
        grant = GRANT_PIPE;
      end else if (req1_valid_i) begin
        grant = GRANT_MDU;
      end
    end
  end

  assign req0_ready_o = (grant == GRANT_PIPE);
  assign req1_ready_o = (grant == GRANT_MDU);

  always_comb begin
    sel_req = wb_pack(req0_rd_i, req0_wdata_i);
    sel_src = WB_SRC_PIPE;
    if (grant == GRANT_MDU) begin
      sel_req = wb_pack(req1_rd_i, req1_wdata_i);
      sel_src = WB_SRC_MDU;
    end
  end

  assign sel_rd    = sel_req[WB_REQ_WIDTH-1:WB_DATA_WIDTH];
  assign sel_wdata = sel_req[WB_DATA_WIDTH-1:0];

  // Writes to x0 are accepted and consumed but never reach the file.
  always_ff @(posedge clock) begin
    if (reset) begin
      rf_we_o    <= 1'b0;
      rf_rd_o    <= '0;
      rf_wdata_o <= '0;
      rf_src_o   <= WB_SRC_PIPE;
    end else if (grant != GRANT_NONE) begin
      rf_we_o    <= (sel_rd != '0);
      rf_rd_o    <= sel_rd;
      rf_wdata_o <= sel_wdata;
      rf_src_o   <= sel_src;
    end else begin
      rf_we_o    <= 1'b0;
    end
  end

`ifdef WB_ARB_STAT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_conflict_o <= '0;
    end else if (req0_valid_i && req1_valid_i) begin
      stat_conflict_o <= stat_conflict_o + 32'd1;
    end
  end
`endif

endmodule
